sfp_iter_div: RTL and testbench

// - Parametrised iterative integer divider for the SFP datapath; next generation of the fixed 20-bit radix-2 divider.
// - Adds selectable width and radix (2 or 4), a remainder output, a valid/ready handshake on both sides and a divide-by-zero flag.
// - Sits between the SFP normaliser and the accumulator writeback. Processes one division at a time.

---
 rtl/sfp_div_pkg.sv | 18 +
 rtl/sfp_div_step.sv | 57 +++++
 rtl/sfp_iter_div.sv | 163 ++++++++++++++++
 tb/tb_sfp_iter_div.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_div_pkg.sv
// Shared types and constants for the SFP iterative divider.
package sfp_div_pkg;

  // Widest radix the step datapath supports (radix-4).
  localparam int SFP_DIV_MAX_RADIX_LOG2 = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sfp_div_state_e;

  // Number of iteration cycles for a given width and radix.
  function automatic int sfp_div_iters(input int width, input int radix_log2);
    return width / radix_log2;
  endfunction

endpackage

// File: rtl/sfp_div_step.sv
// One combinational iteration of the restoring divider: shift the next
// dividend bits into the partial remainder, subtract the largest multiple
// of the divisor that fits and shift that multiple into the quotient.
module sfp_div_step
  import sfp_div_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int RADIX_LOG2 = 1
) (
  input  logic [WIDTH-1:0] acc,         // partial remainder, always < divisor
  input  logic [WIDTH-1:0] quo,         // dividend bits still to retire, quotient bits so far
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH+1:0] divisor_x3,  // 3*divisor, only consulted for radix-4
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next
);

  localparam int AW   = WIDTH + RADIX_LOG2;
  localparam int CW   = WIDTH + SFP_DIV_MAX_RADIX_LOG2;
  localparam int KMAX = (1 << RADIX_LOG2) - 1;

  logic [AW-1:0]         acc_shift;
  logic [CW-1:0]         acc_ext;
  logic [CW-1:0]         mult [KMAX+1];
  logic [KMAX:1]         fits;
  logic [RADIX_LOG2-1:0] k;

  // The accumulator is WIDTH+RADIX_LOG2 bits: remainder with new dividend bits appended.
  assign acc_shift = {acc, quo[WIDTH-1 -: RADIX_LOG2]};
  assign acc_ext   = CW'(acc_shift);
  assign mult[0]   = '0;

  // Candidate multiples k*divisor and whether each fits under the accumulator.
  for (genvar gi = 1; gi <= KMAX; gi++) begin : g_mult
    if (gi == 1) begin : g_x1
      assign mult[gi] = CW'(divisor);
    end else if (gi == 2) begin : g_x2
      assign mult[gi] = CW'({divisor, 1'b0});
    end else begin : g_x3
      assign mult[gi] = divisor_x3;
    end
    assign fits[gi] = (acc_ext >= mult[gi]);
  end

  // Fits is monotone in k, so the last hit is the largest usable digit.
  always_comb begin
    k = '0;
    for (int i = 1; i <= KMAX; i++) begin
      if (fits[i]) k = i[RADIX_LOG2-1:0];
    end
  end

  // The new remainder is below the divisor, so WIDTH bits hold it exactly.
  assign acc_next = WIDTH'(acc_ext - mult[k]);
  assign quo_next = {quo[WIDTH-RADIX_LOG2-1:0], k};

endmodule

// File: rtl/sfp_iter_div.sv
// Parametrised iterative integer divider (radix-2 or radix-4) with
// valid/ready handshakes, remainder output and divide-by-zero flag.
// Optional feature: define SFP_DIV_SIGNED_EN to honour in_signed
// (two's complement operands, truncation toward zero).
module sfp_iter_div
  import sfp_div_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int RADIX_LOG2 = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int N    = sfp_div_iters(WIDTH, RADIX_LOG2);
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  sfp_div_state_e   state_reg, state_next;
  logic [CNTW-1:0]  cnt_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH+1:0] div3_reg;
  logic [WIDTH-1:0] quo_reg, rem_reg;
  logic             dbz_reg;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] b_x3;
  logic [WIDTH-1:0] step_acc, step_quo;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  assign accept = in_valid & in_ready;
  assign b_zero = (b == '0);
  assign quo    = quo_reg;
  assign rem    = rem_reg;
  assign dbz    = dbz_reg;

`ifdef SFP_DIV_SIGNED_EN
  logic neg_quo_reg, neg_rem_reg;
  logic a_neg, b_neg;

  // Signed operands are divided as magnitudes; signs are restored on the way out.
  always_comb begin
    a_neg = in_signed & a[WIDTH-1];
    b_neg = in_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Quotient takes sign(a)^sign(b), remainder takes sign(a); MIN/-1 wraps to MIN.
  always_comb begin
    quo_fin = neg_quo_reg ? -step_quo : step_quo;
    rem_fin = neg_rem_reg ? -step_acc : step_acc;
  end

  // Sign flags captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else if (accept) begin
      neg_quo_reg <= a_neg ^ b_neg;
      neg_rem_reg <= a_neg;
    end
  end
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign quo_fin = step_quo;
  assign rem_fin = step_acc;
`endif

  assign b_x3 = {2'b00, b_mag} + {1'b0, b_mag, 1'b0};

  sfp_div_step #(
    .WIDTH      (WIDTH),
    .RADIX_LOG2 (RADIX_LOG2)
  ) u_step (
    .acc        (acc_reg),
    .quo        (work_reg),
    .divisor    (div_reg),
    .divisor_x3 (div3_reg),
    .acc_next   (step_acc),
    .quo_next   (step_quo)
  );

  // Next state and handshake outputs; nothing is accepted while in reset.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_next = b_zero ? DONE : CALC;
      end
      CALC: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand load, iteration and result registers; results hold after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      work_reg <= '0;
      div_reg  <= '0;
      div3_reg <= '0;
      quo_reg  <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else if (accept) begin
      cnt_reg <= '0;
      if (b_zero) begin
        quo_reg <= '1;
        rem_reg <= a;
        dbz_reg <= 1'b1;
      end else begin
        dbz_reg  <= 1'b0;
        acc_reg  <= '0;
        work_reg <= a_mag;
        div_reg  <= b_mag;
        div3_reg <= b_x3;
      end
    end else if (state_reg == CALC) begin
      acc_reg  <= step_acc;
      work_reg <= step_quo;
      if (cnt_reg == LAST) begin
        quo_reg <= quo_fin;
        rem_reg <= rem_fin;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sfp_iter_div.sv
// Scoreboard bench: a radix-2 and a radix-4 divider receive identical
// operands; expected results from a plain-arithmetic model are queued at
// accept and checked by a monitor when each result appears.
module tb_sfp_iter_div;

  localparam int W  = 20;
  localparam int N2 = W / 1;
  localparam int N4 = W / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] a, b;
  logic         in_signed;
  logic         iv [2];
  logic         ir [2];
  logic         ov [2];
  logic         ordy [2] = '{1'b0, 1'b0};
  logic         dz [2];
  logic [W-1:0] q [2];
  logic [W-1:0] r [2];

  sfp_iter_div #(.WIDTH(W), .RADIX_LOG2(1)) u_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_signed(in_signed),
    .a(a), .b(b), .out_valid(ov[0]), .out_ready(ordy[0]), .quo(q[0]), .rem(r[0]), .dbz(dz[0]));

  sfp_iter_div #(.WIDTH(W), .RADIX_LOG2(2)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_signed(in_signed),
    .a(a), .b(b), .out_valid(ov[1]), .out_ready(ordy[1]), .quo(q[1]), .rem(r[1]), .dbz(dz[1]));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           acc;
  } exp_t;

  exp_t         eq [2][$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic         seen [2] = '{1'b0, 1'b0};
  logic         drained [2] = '{1'b0, 1'b0};
  int           hold [2] = '{0, 0};
  logic [W-1:0] cq [2];
  logic [W-1:0] cr [2];
  logic         cz [2];
  bit           bp_directed = 1'b0;
  exp_t         mon_e;
  int           mon_lat;

  task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d actual=%0h required=%0h t=%0t", nm, lane, act, exp, $time);
    end
  endtask

  // Reference: plain integer division following the documented rules.
  function automatic exp_t ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sv, input int acc);
    exp_t e;
    int sa, sb;
    logic [31:0] tq, tr;
    e.a = av; e.b = bv; e.s = sv; e.acc = acc;
    if (bv == '0) begin
      e.q = '1; e.r = av; e.z = 1'b1;
    end else begin
      e.z = 1'b0;
      tq = 32'(av / bv);
      tr = 32'(av % bv);
`ifdef SFP_DIV_SIGNED_EN
      if (sv) begin
        sa = int'({{(32-W){av[W-1]}}, av});
        sb = int'({{(32-W){bv[W-1]}}, bv});
        tq = 32'(sa / sb);
        tr = 32'(sa % sb);
      end
`else
      sa = 0; sb = 0;
`endif
      e.q = tq[W-1:0];
      e.r = tr[W-1:0];
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard push at the accepting edge.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++)
        if (iv[i] && ir[i]) eq[i].push_back(ref_div(a, b, in_signed, cyc));
    end
  end

  // Monitor: compare new results, check stability under backpressure, drive out_ready.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n !== 1'b1) begin
        eq[i].delete();
        seen[i] = 1'b0; drained[i] = 1'b0; hold[i] = 0; ordy[i] = 1'b0;
      end else if (ov[i]) begin
        chk("in_ready_while_done", i, 32'(ir[i]), 32'd0);
        if (!seen[i]) begin
          if (eq[i].size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_result lane%0d actual quo=%0h rem=%0h required none", i, q[i], r[i]);
          end else begin
            mon_e = eq[i].pop_front();
            mon_lat = cyc - mon_e.acc;
            chk("quo", i, 32'(q[i]), 32'(mon_e.q));
            chk("rem", i, 32'(r[i]), 32'(mon_e.r));
            chk("dbz", i, 32'(dz[i]), 32'(mon_e.z));
            chk("latency", i, 32'(mon_lat), mon_e.z ? 32'd1 : ((i == 0) ? 32'(N2 + 1) : 32'(N4 + 1)));
            $display("txn lane%0d a=%05h b=%05h s=%0d quo=%05h rem=%05h dbz=%0d lat=%0d",
                     i, mon_e.a, mon_e.b, mon_e.s, q[i], r[i], dz[i], mon_lat);
          end
          cq[i] = q[i]; cr[i] = r[i]; cz[i] = dz[i];
          seen[i] = 1'b1;
          hold[i] = bp_directed ? 5 : 0;
        end else begin
          chk("stable_quo", i, 32'(q[i]), 32'(cq[i]));
          chk("stable_rem", i, 32'(r[i]), 32'(cr[i]));
          chk("stable_dbz", i, 32'(dz[i]), 32'(cz[i]));
        end
        if (hold[i] > 0) begin
          ordy[i] = 1'b0;
          hold[i]--;
        end else if (bp_directed) begin
          ordy[i] = 1'b1;
        end else begin
          ordy[i] = ($urandom_range(0, 3) != 0);
        end
        if (ordy[i]) begin
          seen[i] = 1'b0;
          drained[i] = 1'b1;
        end
      end else begin
        if (drained[i]) chk("in_ready_after_drain", i, 32'(ir[i]), 32'd1);
        drained[i] = 1'b0;
        ordy[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Present one operand pair to both dividers until each has accepted it.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int t;
    bit go0, go1;
    @(negedge clk);
    a = av; b = bv; in_signed = sv;
    iv[0] = 1'b1; iv[1] = 1'b1;
    t = 0;
    while ((iv[0] || iv[1]) && t < 500) begin
      go0 = iv[0] && ir[0];
      go1 = iv[1] && ir[1];
      @(negedge clk);
      if (go0) iv[0] = 1'b0;
      if (go1) iv[1] = 1'b0;
      t++;
    end
    if (iv[0] || iv[1]) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual iv=%0d%0d required accepted within 500 cycles", iv[0], iv[1]);
      iv[0] = 1'b0; iv[1] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((eq[0].size() != 0 || eq[1].size() != 0 || ov[0] || ov[1]) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual pending=%0d/%0d required 0", eq[0].size(), eq[1].size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] av, bv;
    logic sv;
    int sel;

    rst_n = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
    a = '0; b = '0; in_signed = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_in_ready", i, 32'(ir[i]), 32'd0);
      chk("rst_quo", i, 32'(q[i]), 32'd0);
      chk("rst_rem", i, 32'(r[i]), 32'd0);
      chk("rst_dbz", i, 32'(dz[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    issue(20'd100, 20'd7, 1'b0);
    issue(20'hFFFFF, 20'd1, 1'b0);
    issue(20'd5, 20'd0, 1'b0);
    issue(20'd9, 20'd3, 1'b0);
    wait_idle();

    // Held backpressure: five cycles of out_ready low on each result.
    bp_directed = 1'b1;
    issue(20'd1000, 20'd13, 1'b0);
    issue(20'd77, 20'd0, 1'b0);
    wait_idle();
    bp_directed = 1'b0;

    // Reset pulse while both dividers are iterating.
    issue(20'd12345, 20'd77, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_out_valid", i, 32'(ov[i]), 32'd0);
      chk("midrst_in_ready", i, 32'(ir[i]), 32'd0);
      chk("midrst_quo", i, 32'(q[i]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(20'd9, 20'd3, 1'b0);
    wait_idle();

    // Signed corner cases (plain unsigned when the feature is compiled out).
    issue(20'hFFFF9, 20'd2, 1'b1);
    issue(20'h80000, 20'hFFFFF, 1'b1);
    issue(20'hFFFF9, 20'd0, 1'b1);

    // Randomised traffic.
    repeat (40) begin
      sel = $urandom_range(0, 7);
      av = W'($urandom);
      if ($urandom_range(0, 9) == 0) av = 20'h80000;
      case (sel)
        0:       bv = '0;
        1, 2:    bv = W'($urandom_range(1, 15));
        3:       bv = '1;
        default: bv = W'($urandom);
      endcase
      sv = 1'($urandom_range(0, 1));
      issue(av, bv, sv);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
